// File: rtl/audio_sdr_xfer.sv
// Record/playback mover between the audio codec and SDRAM: single-word write path, one-word prefetch read path.
// Build option: UNDERRUN_HOLD_EN repeats the last sample on underrun instead of outputting silence.
module audio_sdr_xfer #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 960000
) (
  input  logic              clk50M,
  input  logic              reset_n,
  input  logic              record_en,
  input  logic              play_en,
  input  logic              sdr_waddr_set,
  input  logic              sdr_raddr_set,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_count,
  output logic              ovf,
  output logic              unf
);

  typedef enum logic {W_IDLE, W_REQ} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_FULL} rstate_t;

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_WORDS);

  wstate_t           wst;
  rstate_t           rst;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              wpend;
  logic              rpend;
  logic [DATA_W-1:0] pbuf;

  // The committed-sample count always equals the next write address.
  assign wr_count = waddr;

  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      wst     <= W_IDLE;
      waddr   <= '0;
      wpend   <= 1'b0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ovf     <= 1'b0;
    end else begin
      case (wst)
        W_IDLE: begin
          if (sdr_waddr_set) begin
            waddr <= '0;
            ovf   <= 1'b0;
          end else if (record_en && adc_valid && (waddr < MAX_A)) begin
            wr_data <= adc_data;
            wr_addr <= waddr;
            wr_req  <= 1'b1;
            wst     <= W_REQ;
          end
        end
        W_REQ: begin
          if (adc_valid) ovf <= 1'b1;
          if (wr_ack) begin
            wr_req <= 1'b0;
            wpend  <= 1'b0;
            // A rewind seen while the write was in flight takes effect at the ack.
            waddr  <= (wpend || sdr_waddr_set) ? '0 : waddr + 1'b1;
            wst    <= W_IDLE;
          end else if (sdr_waddr_set) begin
            wpend <= 1'b1;
          end
        end
        default: wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      rst      <= R_IDLE;
      raddr    <= '0;
      rpend    <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      pbuf     <= '0;
      dac_data <= '0;
      unf      <= 1'b0;
    end else begin
      // Strobe with nothing buffered; the state-specific rewind below overrides this.
      if (dac_req && (rst != R_FULL)) begin
        if (play_en) begin
          unf <= 1'b1;
`ifdef UNDERRUN_HOLD_EN
          dac_data <= dac_data;
`else
          dac_data <= '0;
`endif
        end else begin
          dac_data <= '0;
        end
      end
      case (rst)
        R_IDLE: begin
          if (sdr_raddr_set) begin
            raddr    <= '0;
            dac_data <= '0;
            unf      <= 1'b0;
          end else if (play_en && (raddr < wr_count)) begin
            rd_req  <= 1'b1;
            rd_addr <= raddr;
            rst     <= R_REQ;
          end
        end
        R_REQ: begin
          if (sdr_raddr_set) rpend <= 1'b1;
          if (rd_ack) begin
            rd_req <= 1'b0;
            rst    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_valid) begin
            if (rpend || sdr_raddr_set) begin
              raddr    <= '0;
              rpend    <= 1'b0;
              dac_data <= '0;
              unf      <= 1'b0;
              rst      <= R_IDLE;
            end else begin
              pbuf  <= rd_data;
              raddr <= raddr + 1'b1;
              rst   <= R_FULL;
            end
          end else if (sdr_raddr_set) begin
            rpend <= 1'b1;
          end
        end
        R_FULL: begin
          if (sdr_raddr_set) begin
            raddr    <= '0;
            dac_data <= '0;
            unf      <= 1'b0;
            rst      <= R_IDLE;
          end else if (dac_req) begin
            dac_data <= pbuf;
            rst      <= R_IDLE;
          end
        end
        default: rst <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sdr_xfer.sv
// Bench for audio_sdr_xfer: directed tables plus a randomized record/play run against a sample-level model.
module tb_audio_sdr_xfer;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int MAXW = 4;
`ifdef UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk50M, reset_n;
  logic          record_en, play_en, sdr_waddr_set, sdr_raddr_set;
  logic          adc_valid, dac_req, wr_ack, rd_ack, rd_valid;
  logic [DW-1:0] adc_data, dac_data, wr_data, rd_data;
  logic          wr_req, rd_req, ovf, unf;
  logic [AW-1:0] wr_addr, rd_addr, wr_count;

  audio_sdr_xfer #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXW)) dut (
    .clk50M(clk50M), .reset_n(reset_n), .record_en(record_en), .play_en(play_en),
    .sdr_waddr_set(sdr_waddr_set), .sdr_raddr_set(sdr_raddr_set),
    .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req), .dac_data(dac_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_count(wr_count), .ovf(ovf), .unf(unf)
  );

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  logic [DW-1:0] sdr_mem [0:15];

  // SDRAM storage: every acked write lands here.
  always @(posedge clk50M) begin
    if (wr_req && wr_ack) begin
      sdr_mem[wr_addr[3:0]] <= wr_data;
      nwr <= nwr + 1;
    end
  end

  task automatic step();
    @(posedge clk50M); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Read responder: ack after 0..2 cycles, data 1..2 cycles after the ack.
  initial begin : rd_resp
    logic [AW-1:0] ra;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      step();
      if (rd_req) begin
        ra = rd_addr;
        repeat ($urandom_range(0, 2)) step();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        repeat ($urandom_range(0, 1)) step();
        rd_valid = 1'b1;
        rd_data  = sdr_mem[ra[3:0]];
        step();
        rd_valid = 1'b0;
      end
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] addr;
    logic [AW-1:0] cnt;
  } wvec_t;

  typedef struct {
    logic [DW-1:0] dac;
    logic          unf;
  } rvec_t;

  wvec_t wvec [3];
  rvec_t rvec [4];

  // Sample-level model state for the random run
  int            cnt, wt, paddr, n0;
  bit            busy, pend, movf, rec, av, ws, ack;
  logic [DW-1:0] d, pdata, expd, last;
  logic [DW-1:0] mmem [0:MAXW-1];

  initial begin
    wvec[0] = '{16'h1111, 24'd0, 24'd1};
    wvec[1] = '{16'h2222, 24'd1, 24'd2};
    wvec[2] = '{16'h3333, 24'd2, 24'd3};
    rvec[0] = '{16'h1111, 1'b0};
    rvec[1] = '{16'h2222, 1'b0};
    rvec[2] = '{16'h3333, 1'b0};
    rvec[3] = '{HOLD ? 16'h3333 : 16'h0000, 1'b1};

    reset_n = 1'b0; record_en = 0; play_en = 0; sdr_waddr_set = 0; sdr_raddr_set = 0;
    adc_valid = 0; adc_data = '0; dac_req = 0; wr_ack = 0;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Reset in the middle of a pending write
    record_en = 1; adc_valid = 1; adc_data = 16'h5555;
    step();
    adc_valid = 0;
    chk("t1_req_before_reset", wr_req, 1);
    step();
    reset_n = 0;
    step();
    chk("t1_wr_req_in_reset", wr_req, 0);
    step(); step();
    reset_n = 1;
    step();
    chk("t1_wr_req", wr_req, 0);
    chk("t1_wr_count", wr_count, 0);
    chk("t1_ovf", ovf, 0);
    chk("t1_unf", unf, 0);
    chk("t1_dac_data", dac_data, 0);
    chk("t1_rd_req", rd_req, 0);

    // Three recorded samples, ack two cycles after each request
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1; adc_data = wvec[i].d;
      step();
      adc_valid = 0;
      chk("t2_wr_req", wr_req, 1);
      chk("t2_wr_addr", wr_addr, wvec[i].addr);
      chk("t2_wr_data", wr_data, wvec[i].d);
      step();
      wr_ack = 1;
      step();
      wr_ack = 0;
      chk("t2_wr_req_drop", wr_req, 0);
      chk("t2_wr_count", wr_count, wvec[i].cnt);
    end
    chk("t2_ovf", ovf, 0);
    record_en = 0;

    // Play the recording back, one strobe every 20 cycles
    sdr_raddr_set = 1; step(); sdr_raddr_set = 0;
    play_en = 1;
    for (int i = 0; i < 4; i++) begin
      repeat (19) step();
      dac_req = 1;
      step();
      dac_req = 0;
      chk("t4_dac_data", dac_data, rvec[i].dac);
      chk("t4_unf", unf, rvec[i].unf);
    end
    chk("t4_no_read_at_end", rd_req, 0);
    play_en = 0;
    step();

    // Overflow while the ack is withheld
    sdr_waddr_set = 1; step(); sdr_waddr_set = 0;
    chk("t3_count_rewound", wr_count, 0);
    record_en = 1; adc_valid = 1; adc_data = 16'hAAAA;
    step();
    adc_valid = 0;
    repeat (3) step();
    adc_valid = 1; adc_data = 16'hBBBB;
    step();
    adc_valid = 0;
    chk("t3_ovf", ovf, 1);
    repeat (5) step();
    chk("t3_wr_req_held", wr_req, 1);
    chk("t3_wr_addr_frozen", wr_addr, 0);
    chk("t3_wr_data_frozen", wr_data, 16'hAAAA);
    wr_ack = 1; step(); wr_ack = 0;
    chk("t3_wr_count", wr_count, 1);

    // Rewind requested while a write is pending
    adc_valid = 1; adc_data = 16'hCCCC;
    step();
    adc_valid = 0;
    chk("t5_wr_addr", wr_addr, 1);
    sdr_waddr_set = 1; step(); sdr_waddr_set = 0;
    step();
    wr_ack = 1; step(); wr_ack = 0;
    chk("t5_wr_count_zero", wr_count, 0);
    adc_valid = 1; adc_data = 16'hDDDD;
    step();
    adc_valid = 0;
    chk("t5_next_addr", wr_addr, 0);
    wr_ack = 1; step(); wr_ack = 0;
    chk("t5_wr_count_one", wr_count, 1);

    // Capacity saturation
    sdr_waddr_set = 1; step(); sdr_waddr_set = 0;
    chk("t6_ovf_cleared", ovf, 0);
    n0 = nwr;
    for (int i = 0; i < 6; i++) begin
      adc_valid = 1; adc_data = DW'(i);
      step();
      adc_valid = 0;
      chk("t6_wr_req", wr_req, (i < MAXW) ? 1 : 0);
      if (wr_req) begin
        chk("t6_wr_addr", wr_addr, i);
        wr_ack = 1; step(); wr_ack = 0;
      end
      step();
    end
    chk("t6_writes", nwr - n0, MAXW);
    chk("t6_wr_count", wr_count, MAXW);
    chk("t6_ovf", ovf, 0);

    // Random recording against the sample-level model
    sdr_waddr_set = 1; step(); sdr_waddr_set = 0;
    cnt = 0; busy = 0; pend = 0; movf = 0; wt = 0; paddr = 0; pdata = '0;
    for (int c = 0; c < 600 || busy; c++) begin
      rec = ($urandom_range(0, 9) != 0);
      av  = (c < 600) && ($urandom_range(0, 2) == 0);
      ws  = ($urandom_range(0, 39) == 0);
      d   = DW'($urandom);
      ack = busy && (wt == 0);
      record_en = rec; adc_valid = av; adc_data = d; sdr_waddr_set = ws; wr_ack = ack;
      if (!busy) begin
        if (ws) begin
          cnt = 0; movf = 0;
        end else if (rec && av && cnt < MAXW) begin
          busy = 1; pdata = d; paddr = cnt; wt = $urandom_range(0, 4);
        end
      end else begin
        if (av) movf = 1;
        if (ws) pend = 1;
        if (ack) begin
          busy = 0;
          mmem[paddr] = pdata;
          cnt = pend ? 0 : cnt + 1;
          pend = 0;
        end else begin
          wt--;
        end
      end
      step();
      chk("rnd_wr_req", wr_req, busy);
      chk("rnd_wr_count", wr_count, cnt);
      chk("rnd_ovf", ovf, movf);
      if (busy) begin
        chk("rnd_wr_addr", wr_addr, paddr);
        chk("rnd_wr_data", wr_data, pdata);
      end
    end
    record_en = 0; adc_valid = 0; sdr_waddr_set = 0; wr_ack = 0;

    // Random-gap playback of whatever was recorded, then two underruns
    sdr_raddr_set = 1; step(); sdr_raddr_set = 0;
    play_en = 1;
    last = '0;
    for (int k = 0; k < cnt + 2; k++) begin
      repeat ($urandom_range(12, 20)) step();
      dac_req = 1;
      step();
      dac_req = 0;
      expd = (k < cnt) ? mmem[k] : (HOLD ? last : '0);
      last = expd;
      chk("rnd_dac_data", dac_data, expd);
      chk("rnd_unf", unf, (k < cnt) ? 0 : 1);
    end
    play_en = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_sdr_xfer.md
Name: audio_sdr_xfer

Overview:
- Sits directly downstream of the key debounce / record-play control block; consumes record_en, play_en, sdr_waddr_set and sdr_raddr_set.
- Record path: moves ADC samples into SDRAM through a single-word write request/ack handshake.
- Play path: prefetches SDRAM words through a read request/ack/valid handshake and hands one sample per DAC strobe to the audio codec serializer.

Parameters:
ADDR_W, 24, SDRAM word address width
DATA_W, 16, audio sample width
MAX_WORDS, 960000, record capacity in samples (48 kHz x 20 s); write address saturates here

Ports:
clk50M  in  1  system clock, 50 MHz
reset_n  in  1  reset
record_en  in  1  level; recording allowed
play_en  in  1  level; playback allowed
sdr_waddr_set  in  1  level/pulse; rewind write pointer to 0
sdr_raddr_set  in  1  level/pulse; rewind read pointer to 0
adc_valid  in  1  one-cycle strobe; adc_data valid
adc_data  in  DATA_W  captured ADC sample
dac_req  in  1  one-cycle strobe; DAC consumes next sample
dac_data  out  DATA_W  sample to DAC, registered
wr_req  out  1  SDRAM write request, held until wr_ack
wr_addr  out  ADDR_W  write address, stable while wr_req=1
wr_data  out  DATA_W  write data, stable while wr_req=1
wr_ack  in  1  one-cycle write accept
rd_req  out  1  SDRAM read request, held until rd_ack
rd_addr  out  ADDR_W  read address, stable while rd_req=1
rd_ack  in  1  one-cycle read accept
rd_valid  in  1  one-cycle read data strobe, at least 1 cycle after rd_ack
rd_data  in  DATA_W  read data
wr_count  out  ADDR_W  number of samples committed in the current recording
ovf  out  1  sticky; ADC sample dropped because a write was still pending
unf  out  1  sticky; dac_req arrived with the prefetch buffer empty while play_en=1

Behaviour:
- Reset is synchronous and active-low on reset_n, clocked by clk50M. While reset_n=0, every register and output is 0 and both FSMs are in their IDLE state.
- Write FSM, W_IDLE -> W_REQ:
  - In W_IDLE with sdr_waddr_set=1: waddr, wr_count, ovf <= 0.
  - In W_IDLE with record_en=1, adc_valid=1, sdr_waddr_set=0 and waddr<MAX_WORDS: latch wr_data<=adc_data and wr_addr<=waddr, set wr_req<=1 the next cycle, go to W_REQ.
  - In W_IDLE with waddr==MAX_WORDS: samples are ignored silently; ovf is not set.
- Write FSM, in W_REQ:
  - wr_req stays high and wr_addr/wr_data are frozen, even if record_en drops.
  - adc_valid in W_REQ: sample dropped, ovf<=1.
  - On wr_ack: wr_req<=0; waddr<=waddr+1; wr_count<=waddr+1; return to W_IDLE.
  - If sdr_waddr_set was seen at any point during W_REQ, the ack instead zeroes waddr and wr_count (pending-rewind flag).
- Read FSM, states R_IDLE, R_REQ, R_WAIT, R_FULL; one-word prefetch buffer.
  - R_IDLE with play_en=1, sdr_raddr_set=0 and raddr<wr_count: rd_req<=1, rd_addr<=raddr, go to R_REQ.
  - R_REQ: hold until rd_ack, then rd_req<=0, go to R_WAIT.
  - R_WAIT: on rd_valid, buf<=rd_data, raddr<=raddr+1, go to R_FULL.
  - R_FULL: on dac_req, dac_data<=buf (next cycle), go to R_IDLE.
- dac_req in any state other than R_FULL:
  - play_en=1: unf<=1, underrun output (see Optional Feature).
  - play_en=0: dac_data<=0; unf unchanged.
- sdr_raddr_set:
  - In R_IDLE or R_FULL: raddr<=0, buffer discarded, state R_IDLE, dac_data<=0, unf<=0.
  - In R_REQ or R_WAIT: pending flag set; the transaction completes, the returned word is discarded, then the rewind is applied and the FSM returns to R_IDLE.
- play_en falling: no new read is issued; an outstanding read completes into buf.
- Latency: adc_valid to wr_req = 1 cycle; dac_req to dac_data = 1 cycle.
- raddr==wr_count: end of recording. No reads are issued; further dac_req while play_en=1 counts as underrun.
- adc_valid and dac_req in the same cycle are independent. Write and read handshakes may overlap; arbitration between them belongs to the SDRAM controller.

Optional Feature:
UNDERRUN_HOLD_EN
- Defined: on underrun, dac_data keeps its previous value (last sample is repeated).
- Undefined: on underrun, dac_data<=0 (silence).
- unf behaves identically in both builds.

Test Plan:
1. reset_n=0 for 3 cycles mid-W_REQ -> wr_req=0, wr_count=0, ovf=0, unf=0, dac_data=0 on the following cycle.
2. record_en=1, 3 adc_valid strobes 0x1111/0x2222/0x3333, wr_ack 2 cycles after each wr_req -> writes to addr 0,1,2 with matching data; wr_count=3; ovf=0.
3. adc_valid twice while wr_ack is withheld for 10 cycles -> second sample dropped, ovf=1; wr_addr/wr_data unchanged until the ack; wr_count=1 after the ack.
4. After test 2, pulse sdr_raddr_set, play_en=1, rd_valid returns memory contents, dac_req every 20 cycles -> dac_data sequence 0x1111, 0x2222, 0x3333; fourth dac_req gives unf=1 and dac_data=0 (0x3333 with UNDERRUN_HOLD_EN).
5. sdr_waddr_set asserted while in W_REQ -> after wr_ack, wr_count=0; next write goes to addr 0.
6. MAX_WORDS=4, 6 adc_valid strobes with prompt acks -> exactly 4 writes (addr 0..3), wr_count=4, ovf=0.
